// File: rtl/iter_counter.sv
// Programmable iteration counter (up/down, one-shot/auto-reload) with start/busy/done FSM.
// Optional ITER_PRESCALE_EN macro adds a per-step prescaler (presc input).
module iter_counter #(
  parameter int DW   = 8,
  parameter int INIT = 7
`ifdef ITER_PRESCALE_EN
  , parameter int PRESCALE_W = 4
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          ena,
  input  logic          up,
  input  logic          auto_reload,
  input  logic [DW-1:0] load_val,
`ifdef ITER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] presc,
`endif
  output logic [DW-1:0] count,
  output logic          busy,
  output logic          tc,
  output logic          done,
  output logic [1:0]    state_dbg
);

  // Handshake: start is a one-cycle request accepted in any state (abort wins);
  // busy is high for the whole pass; done is a one-cycle pulse per completed pass.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] count_n;
  logic          busy_n, done_n;
  logic          dir_q, dir_n;
  logic          reload_q, reload_n;
  logic [DW-1:0] target_q, target_n;
  logic [DW-1:0] load_q, load_n;
  logic          at_target;
  logic          presc_hit;

`ifdef ITER_PRESCALE_EN
  logic [PRESCALE_W-1:0] presc_q, presc_n;
  logic [PRESCALE_W-1:0] pcnt, pcnt_n;
  assign presc_hit = (pcnt == presc_q);
`else
  assign presc_hit = 1'b1;
`endif

  assign at_target = (count == target_q);
  assign tc        = (state == S_RUN) && at_target && presc_hit;
  assign state_dbg = state;

  always_comb begin
    state_n  = state;
    count_n  = count;
    busy_n   = busy;
    done_n   = 1'b0;
    dir_n    = dir_q;
    reload_n = reload_q;
    target_n = target_q;
    load_n   = load_q;
`ifdef ITER_PRESCALE_EN
    presc_n  = presc_q;
    pcnt_n   = pcnt;
`endif
    if (abort) begin
      state_n = S_IDLE;
      count_n = DW'(INIT);
      busy_n  = 1'b0;
`ifdef ITER_PRESCALE_EN
      pcnt_n  = '0;
`endif
    end else if (start) begin
      state_n  = S_RUN;
      busy_n   = 1'b1;
      dir_n    = up;
      reload_n = auto_reload;
      load_n   = load_val;
      target_n = up ? load_val : '0;
      count_n  = up ? '0 : load_val;
`ifdef ITER_PRESCALE_EN
      presc_n  = presc;
      pcnt_n   = '0;
`endif
    end else if (state == S_RUN && ena) begin
      if (presc_hit) begin
`ifdef ITER_PRESCALE_EN
        pcnt_n = '0;
`endif
        if (at_target) begin
          done_n = 1'b1;
          if (reload_q) begin
            count_n = dir_q ? '0 : load_q;
          end else begin
            state_n = S_DONE;
            busy_n  = 1'b0;
          end
        end else begin
          count_n = dir_q ? count + 1'b1 : count - 1'b1;
        end
      end else begin
`ifdef ITER_PRESCALE_EN
        pcnt_n = pcnt + 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= DW'(INIT);
      busy     <= 1'b0;
      done     <= 1'b0;
      dir_q    <= 1'b0;
      reload_q <= 1'b0;
      target_q <= '0;
      load_q   <= '0;
`ifdef ITER_PRESCALE_EN
      presc_q  <= '0;
      pcnt     <= '0;
`endif
    end else begin
      state    <= state_n;
      count    <= count_n;
      busy     <= busy_n;
      done     <= done_n;
      dir_q    <= dir_n;
      reload_q <= reload_n;
      target_q <= target_n;
      load_q   <= load_n;
`ifdef ITER_PRESCALE_EN
      presc_q  <= presc_n;
      pcnt     <= pcnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_iter_counter.sv
// Table-driven bench for iter_counter plus hand-written multi-cycle sequences.
module tb_iter_counter;

  logic       clk = 1'b0;
  logic       reset, start, abort, ena, up, auto_reload;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       busy, tc, done;
  logic [1:0] state_dbg;
`ifdef ITER_PRESCALE_EN
  logic [3:0] presc;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iter_counter dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ena(ena),
    .up(up), .auto_reload(auto_reload), .load_val(load_val),
`ifdef ITER_PRESCALE_EN
    .presc(presc),
`endif
    .count(count), .busy(busy), .tc(tc), .done(done), .state_dbg(state_dbg)
  );

  typedef struct {
    logic       rst, st, ab, en, up, ar;
    logic [7:0] lv;
    logic [7:0] cnt;
    logic       b, d, t;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, st, ab, en, u, ar, input logic [7:0] lv,
                     input logic [7:0] cnt, input logic b, d, t);
    vec_t v;
    v.rst = rst; v.st = st; v.ab = ab; v.en = en; v.up = u; v.ar = ar; v.lv = lv;
    v.cnt = cnt; v.b = b; v.d = d; v.t = t;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, st, ab, en, u, ar, input logic [7:0] lv);
    @(negedge clk);
    reset = rst; start = st; abort = ab; ena = en; up = u; auto_reload = ar; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; ena = 1'b0; up = 1'b0;
    auto_reload = 1'b0; load_val = 8'd0;
`ifdef ITER_PRESCALE_EN
    presc = 4'd0;
`endif
    //   rst st ab en up ar lv     cnt  b  d  t
    // reset, then ena ignored in IDLE
    add(1, 0, 0, 0, 0, 0, 8'd0,  8'd7, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 8'd0,  8'd7, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd7, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd7, 0, 0, 0);
    // down one-shot, load 5
    add(0, 1, 0, 0, 0, 0, 8'd5,  8'd5, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd4, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd3, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd2, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 8'd0,  8'd0, 0, 0, 0);
    // up auto-reload, load 3
    add(0, 1, 0, 0, 1, 1, 8'd3,  8'd0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd2, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd3, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd2, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd3, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd1, 1, 0, 0);
    // ena gaps, then abort beats start
    add(0, 1, 0, 0, 0, 0, 8'd4,  8'd4, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 8'd0,  8'd3, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 8'd0,  8'd2, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0, 8'd4,  8'd7, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd7, 0, 0, 0);
    // load 0 completes on first ena
    add(0, 1, 0, 0, 0, 0, 8'd0,  8'd0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 8'd0,  8'd0, 0, 0, 0);
    // restart mid-pass with load 9
    add(0, 1, 0, 0, 0, 0, 8'd8,  8'd8, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd7, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd6, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 8'd9,  8'd9, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd8, 1, 0, 0);
    // start at terminal discards the pending done; later up/load changes ignored
    add(0, 1, 0, 0, 0, 0, 8'd1,  8'd1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd0, 1, 0, 1);
    add(0, 1, 0, 1, 0, 0, 8'd2,  8'd2, 1, 0, 0);
    add(0, 0, 0, 1, 1, 1, 8'd0,  8'd1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 1, 8'd0,  8'd0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd0, 0, 1, 0);
    // reset beats start/ena mid-pass
    add(0, 1, 0, 0, 1, 1, 8'd5,  8'd0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd1, 1, 0, 0);
    add(1, 1, 0, 1, 1, 1, 8'd5,  8'd7, 0, 0, 0);
    // auto-reload with load 0: done every cycle
    add(0, 1, 0, 0, 1, 1, 8'd0,  8'd0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd0, 1, 1, 1);
    add(0, 0, 0, 1, 0, 0, 8'd0,  8'd0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 8'd0,  8'd0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 8'd0,  8'd7, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].ab, vecs[i].en, vecs[i].up, vecs[i].ar, vecs[i].lv);
      chk($sformatf("vec%0d {count,busy,done,tc}", i),
          {5'd0, count, busy, done, tc},
          {5'd0, vecs[i].cnt, vecs[i].b, vecs[i].d, vecs[i].t});
    end

    // up one-shot of 12: done must follow the 13th ena, and only once
    begin
      int  steps;
      bit  seen;
      drive(0, 1, 0, 0, 1, 0, 8'd12);
      steps = 0;
      seen  = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        drive(0, 0, 0, 1, 0, 0, 8'd0);
        steps++;
        if (done) seen = 1'b1;
      end
      if (!seen) begin
        n_vec++;
        n_bad++;
        $display("FAIL up12 done timeout: no done within 40 ena cycles");
      end else begin
        chk("up12 ena steps", 16'(steps), 16'd13);
        chk("up12 final count", {8'd0, count}, 16'd12);
        chk("up12 busy", {15'd0, busy}, 16'd0);
      end
      drive(0, 0, 0, 1, 0, 0, 8'd0);
      chk("up12 single done", {15'd0, done}, 16'd0);
    end

`ifdef ITER_PRESCALE_EN
    // presc 2, down from 1: each step takes 3 ena cycles
    begin
      logic [7:0] exp_c[6] = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
      logic       exp_d[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic       exp_t[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      presc = 4'd2;
      drive(0, 1, 0, 0, 0, 0, 8'd1);
      presc = 4'd0;
      chk("presc start count", {8'd0, count}, 16'd1);
      for (int k = 0; k < 6; k++) begin
        drive(0, 0, 0, 1, 0, 0, 8'd0);
        chk($sformatf("presc ena%0d {count,done,tc}", k + 1),
            {6'd0, count, done, tc}, {6'd0, exp_c[k], exp_d[k], exp_t[k]});
      end
      drive(0, 0, 0, 1, 0, 0, 8'd0);
      chk("presc done once", {15'd0, done}, 16'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
